ex_mdu: RTL
===========

// Module: ex_mdu
// PURPOSE
//  Parametrised execute stage: logic, shift, add/sub, compare, plus HI/LO multiply/divide unit.
//  Sits between ID/EX and EX/MEM; result is registered (built-in EX/MEM latch).
//  Multiply is single-cycle; divide is iterative radix-2 and stalls the pipe via stall_req.
// PARAMETERS
//  DATA_W  32  operand/result width (>=8, even)
//  ADDR_W  5   register-file address width
//  DIV_EN  1   1: divider built; 0: DIV/DIVU retire as NOP, HI/LO untouched
// PORTS
//  clk            in   1         rising-edge clock
//  rst            in   1         sync reset, active-high
//  flush          in   1         kill in-flight op (branch/exception)
//  valid_in       in   1         op presented this cycle
//  aluop_in       in   4         op code (table below)
//  reg1_in        in   DATA_W    operand A (rs)
//  reg2_in        in   DATA_W    operand B (rt / shamt in [log2(DATA_W)-1:0])
//  w_reg_addr_in  in   ADDR_W    destination register
//  w_reg_en_in    in   1         destination write request
//  stall_req      out  1         hold ID/EX inputs stable
//  valid_out      out  1         registered result valid
//  w_reg_addr_out out  ADDR_W    registered destination
//  w_reg_data_out out  DATA_W    registered result
//  w_reg_en_out   out  1         registered write enable
//  hi_out, lo_out out  DATA_W    HI/LO architectural registers
// BEHAVIOUR
//  Ops: 0 NOP,1 OR,2 AND,3 XOR,4 NOR,5 ADD,6 SUB,7 SLT,8 SLTU,9 SLL,10 SRL,11 SRA,
//       12 MULT,13 MULTU,14 DIV,15 DIVU. ADD/SUB wrap mod 2^DATA_W, no overflow trap.
//  SLT/SLTU result = {0..,1} or 0. Shifts use reg2_in[log2(DATA_W)-1:0].
//  Reset: all outputs 0, HI/LO 0, divider FSM IDLE, stall_req 0.
//  Single-cycle ops: accepted when valid_in & !stall_req; outputs valid next edge (latency 1).
//   valid_out=valid_in; w_reg_en_out=w_reg_en_in & op in 1..11; else data=0.
//  MULT/MULTU: {HI,LO} <= full 2*DATA_W product (signed/unsigned) on accept edge;
//   valid_out=1, w_reg_en_out=0 next cycle.
//  Divider FSM: IDLE -> BUSY on accepted DIV/DIVU (DIV_EN=1); BUSY runs DATA_W cycles
//   (counter DATA_W-1..0); BUSY -> DONE when counter=0; DONE -> IDLE after one cycle.
//   stall_req = combinational: 1 when accepted DIV this cycle, or state BUSY; 0 in DONE.
//   Signed: operate on magnitudes, LO=quotient negated if signs differ, HI=remainder with
//   dividend sign (truncating). DONE edge writes HI<=rem, LO<=quot; valid_out=1, w_reg_en_out=0.
//   While stalled valid_out=0; upstream holds inputs; no new op accepted.
//  Divide by zero: no iteration; IDLE->DONE next cycle, HI<=dividend, LO<=all-ones.
//  flush: outputs next edge valid_out=0, w_reg_en_out=0; divider -> IDLE, HI/LO not written;
//   flush has priority over accept, DONE and MULT HI/LO write in the same cycle.
//  rst has priority over flush. Reset mid-division: returns to IDLE, HI/LO=0.
// TESTING
//  rst 2 cycles -> all outputs 0, stall_req 0; then OR 0xF0F0_0000|0x0000_0F0F -> data 0xF0F0_0F0F next cycle.
//  SUB 0x0000_0000-1 -> 0xFFFF_FFFF; SLT 0xFFFF_FFFF,1 -> 1; SLTU same -> 0; SRA 0x8000_0000,4 -> 0xF800_0000.
//  MULT 0xFFFF_FFFE*3 -> HI 0xFFFF_FFFF, LO 0xFFFF_FFFA; MULTU same -> HI 2, LO 0xFFFF_FFFA; w_reg_en_out 0.
//  DIV -7/2 -> stall_req high 33 cycles total, then LO 0xFFFF_FFFD, HI 0xFFFF_FFFF; DIVU 100/7 -> LO 14, HI 2.
//  DIVU 5/0 -> 1 stall cycle, HI 5, LO 0xFFFF_FFFF.
//  flush at BUSY cycle 10 -> stall_req drops next cycle, HI/LO keep prior values; next OR executes normally.

Source files
------------

// File: rtl/ex_mdu.sv
// ex_mdu: registered execute stage with logic/shift/add/compare ALU, single-cycle HI/LO multiply and iterative radix-2 divide.
//   clk, rst                       clock, synchronous active-high reset
//   flush                          kill the in-flight op, divider back to IDLE, HI/LO untouched
//   valid_in, aluop_in             op presented this cycle and its code
//   reg1_in, reg2_in               operands A and B (B low bits give the shift amount)
//   w_reg_addr_in, w_reg_en_in     destination register and write request
//   stall_req                      hold ID/EX inputs while a divide is started or running
//   valid_out, w_reg_*_out         registered result
//   hi_out, lo_out                 HI/LO architectural registers
module ex_mdu #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter bit DIV_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              valid_in,
   input  logic [3:0]        aluop_in,
   input  logic [DATA_W-1:0] reg1_in,
   input  logic [DATA_W-1:0] reg2_in,
   input  logic [ADDR_W-1:0] w_reg_addr_in,
   input  logic              w_reg_en_in,
   output logic              stall_req,
   output logic              valid_out,
   output logic [ADDR_W-1:0] w_reg_addr_out,
   output logic [DATA_W-1:0] w_reg_data_out,
   output logic              w_reg_en_out,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out
);
   localparam int SW = $clog2(DATA_W);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state_q, state_d;
   logic [SW-1:0] cnt_q;
   logic [DATA_W-1:0] rem_q, quot_q, dsr_q, hi_q, lo_q, data_q, alu_res, a_mag, b_mag, rem_nx, quot_nx;
   logic [ADDR_W-1:0] addr_q;
   logic valid_q, en_q, negq_q, negr_q, sgn, is_div, is_mul, acc, div_go, alu_wr, ge, b_zero;
   logic [DATA_W:0] r_sh, diff;
   logic [2*DATA_W-1:0] ma, mb, prod;
   assign sgn    = ~aluop_in[0];
   assign is_div = aluop_in[3:1] == 3'b111;
   assign is_mul = aluop_in[3:1] == 3'b110;
   assign b_zero = reg2_in == '0;
   // Only IDLE accepts: in DONE the finishing divide is still held on the inputs.
   assign acc    = valid_in & (state_q == IDLE) & ~flush;
   assign div_go = acc & is_div & DIV_EN;
   assign alu_wr = (aluop_in != 4'd0) && (aluop_in < 4'd12);
   assign a_mag  = (sgn & reg1_in[DATA_W-1]) ? -reg1_in : reg1_in;
   assign b_mag  = (sgn & reg2_in[DATA_W-1]) ? -reg2_in : reg2_in;
   assign ma     = {{DATA_W{sgn & reg1_in[DATA_W-1]}}, reg1_in};
   assign mb     = {{DATA_W{sgn & reg2_in[DATA_W-1]}}, reg2_in};
   assign prod   = ma * mb;
   // One restoring step: shift the next dividend bit into the partial remainder.
   assign r_sh    = {rem_q, quot_q[DATA_W-1]};
   assign diff    = r_sh - {1'b0, dsr_q};
   assign ge      = ~diff[DATA_W];
   assign rem_nx  = ge ? diff[DATA_W-1:0] : r_sh[DATA_W-1:0];
   assign quot_nx = {quot_q[DATA_W-2:0], ge};
   always_comb begin
      alu_res = '0;
      case (aluop_in)
         4'd1:    alu_res = reg1_in | reg2_in;
         4'd2:    alu_res = reg1_in & reg2_in;
         4'd3:    alu_res = reg1_in ^ reg2_in;
         4'd4:    alu_res = ~(reg1_in | reg2_in);
         4'd5:    alu_res = reg1_in + reg2_in;
         4'd6:    alu_res = reg1_in - reg2_in;
         4'd7:    alu_res = {{(DATA_W-1){1'b0}}, $signed(reg1_in) < $signed(reg2_in)};
         4'd8:    alu_res = {{(DATA_W-1){1'b0}}, reg1_in < reg2_in};
         4'd9:    alu_res = reg1_in << reg2_in[SW-1:0];
         4'd10:   alu_res = reg1_in >> reg2_in[SW-1:0];
         4'd11:   alu_res = $signed(reg1_in) >>> reg2_in[SW-1:0];
         default: alu_res = '0;
      endcase
   end
   always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
   always_comb begin
      state_d = flush ? IDLE :
                state_q == IDLE ? (div_go ? (b_zero ? DONE : BUSY) : IDLE) :
                state_q == BUSY ? (cnt_q == '0 ? DONE : BUSY) : IDLE;
   end
   always_comb begin
      stall_req = div_go | (state_q == BUSY);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         rem_q  <= '0;
         quot_q <= '0;
         dsr_q  <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
      end else if (div_go) begin
         cnt_q  <= SW'(DATA_W-1);
         dsr_q  <= b_mag;
         negq_q <= sgn & (reg1_in[DATA_W-1] ^ reg2_in[DATA_W-1]) & ~b_zero;
         negr_q <= sgn & reg1_in[DATA_W-1] & ~b_zero;
         rem_q  <= b_zero ? reg1_in : '0;
         quot_q <= b_zero ? '1 : a_mag;
      end else if (state_q == BUSY) begin
         cnt_q  <= cnt_q - 1'b1;
         rem_q  <= rem_nx;
         quot_q <= quot_nx;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         en_q    <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
         en_q    <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
      end else if (state_q == DONE) begin
         valid_q <= 1'b1;
         en_q    <= 1'b0;
         data_q  <= '0;
         addr_q  <= w_reg_addr_in;
         hi_q    <= negr_q ? -rem_q : rem_q;
         lo_q    <= negq_q ? -quot_q : quot_q;
      end else if (acc & ~div_go) begin
         valid_q <= 1'b1;
         en_q    <= w_reg_en_in & alu_wr;
         data_q  <= alu_res;
         addr_q  <= w_reg_addr_in;
         if (is_mul) begin
            hi_q <= prod[2*DATA_W-1:DATA_W];
            lo_q <= prod[DATA_W-1:0];
         end
      end else begin
         valid_q <= 1'b0;
         en_q    <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
      end
   end
   assign valid_out      = valid_q;
   assign w_reg_en_out   = en_q;
   assign w_reg_data_out = data_q;
   assign w_reg_addr_out = addr_q;
   assign hi_out         = hi_q;
   assign lo_out         = lo_q;
endmodule
